matraptor_row_dispatcher: RTL

Row-level scheduler between the CSV/DMA triple stream and the `NUM_PES` MatRaptor PEs. It accepts row-sorted `(val,row,col)` triples and assigns each new row to the next free PE in round-robin order. It forwards the row's entries to that PE with a per-row last flag, tracks PE occupancy through `pe_row_done`, and signals when a whole matrix has been dispatched and every PE has finished merging.

---
 rtl/matraptor_row_dispatcher.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/matraptor_row_dispatcher.sv
// Row-level scheduler between the row-sorted triple stream and the MatRaptor PEs.
// Each new row is given to the next free PE in round-robin order. Its entries are
// forwarded through a one-entry hold register. An entry is released only when its
// successor is visible, because that is how the row's last entry is recognised.
// The block tracks PE occupancy and pulses all_done once a whole matrix has been
// dispatched and every PE has gone idle.
module matraptor_row_dispatcher #(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 16,
    parameter int NUM_PES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_val,
    input  logic [IDX_W-1:0]    in_row,
    input  logic [IDX_W-1:0]    in_col,
    input  logic                in_last,
    output logic [NUM_PES-1:0]  pe_valid,
    input  logic [NUM_PES-1:0]  pe_ready,
    output logic [DATA_W-1:0]   pe_val,
    output logic [IDX_W-1:0]    pe_row,
    output logic [IDX_W-1:0]    pe_col,
    output logic                pe_last,
    input  logic [NUM_PES-1:0]  pe_row_done,
    output logic [NUM_PES-1:0]  pe_busy,
    output logic [IDX_W:0]      rows_dispatched,
    output logic                all_done,
    output logic                err_order
);

    localparam int PTR_W = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;

    localparam logic [1:0] S_ASSIGN = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_hold_val;
    logic [IDX_W-1:0]   r_hold_row;
    logic [IDX_W-1:0]   r_hold_col;
    logic               r_hold_last;
    logic               r_hold_v;
    logic [PTR_W-1:0]   r_cur_pe;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_PES-1:0] r_busy;
    logic [IDX_W:0]     r_rows;
    logic               r_err_order;
    logic               r_all_done;

    logic [NUM_PES-1:0] w_free;
    logic [PTR_W-1:0]   w_sel;
    logic               w_any_free;
    logic [PTR_W:0]     w_idx;
    logic [PTR_W:0]     w_sel_inc;
    logic [PTR_W-1:0]   w_rr_next;
    logic               w_in_ready;
    logic [NUM_PES-1:0] w_pe_valid;
    logic               w_pe_last;
    logic               w_hs;
    logic [NUM_PES-1:0] w_busy_set;

    // Round-robin search for the first free PE, starting at r_rr_ptr and wrapping.
    always_comb begin
        w_free     = ~r_busy;
        w_sel      = r_rr_ptr;
        w_any_free = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < NUM_PES; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_PES)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_PES);
            end else begin
                w_idx = w_idx;
            end
            if (!w_any_free && w_free[w_idx[PTR_W-1:0]]) begin
                w_sel      = w_idx[PTR_W-1:0];
                w_any_free = 1'b1;
            end else begin
                w_any_free = w_any_free;
            end
        end
    end

    // Pointer to the PE after the selected one. This is where the next search starts.
    always_comb begin
        w_sel_inc = {1'b0, w_sel} + {{PTR_W{1'b0}}, 1'b1};
        if (w_sel_inc >= (PTR_W+1)'(NUM_PES)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_sel_inc[PTR_W-1:0];
        end
    end

    // Upstream/PE handshake decode. All handshakes are held off while in reset.
    always_comb begin
        w_in_ready = 1'b0;
        w_pe_valid = '0;
        w_pe_last  = 1'b0;
        w_hs       = 1'b0;
        if (!rst_n) begin
            w_in_ready = 1'b0;
        end else begin
            case (r_state)
                S_ASSIGN: begin
                    w_in_ready = w_any_free;
                end
                S_STREAM: begin
                    w_pe_last = r_hold_last || (in_row != r_hold_row);
                    if (r_hold_v && (r_hold_last || in_valid)) begin
                        w_pe_valid[r_cur_pe] = 1'b1;
                        w_hs                 = pe_ready[r_cur_pe];
                    end else begin
                        w_hs = 1'b0;
                    end
                    w_in_ready = w_hs && !w_pe_last;
                end
                S_DRAIN: begin
                    w_in_ready = 1'b0;
                end
                default: begin
                    w_in_ready = 1'b0;
                end
            endcase
        end
    end

    // Occupancy bit to set when a new row is handed to the selected PE.
    always_comb begin
        w_busy_set = '0;
        if ((r_state == S_ASSIGN) && in_valid && w_in_ready) begin
            w_busy_set[w_sel] = 1'b1;
        end else begin
            w_busy_set = '0;
        end
    end

    // Dispatcher state, hold register, occupancy and status counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_ASSIGN;
            r_hold_val  <= '0;
            r_hold_row  <= '0;
            r_hold_col  <= '0;
            r_hold_last <= 1'b0;
            r_hold_v    <= 1'b0;
            r_cur_pe    <= '0;
            r_rr_ptr    <= '0;
            r_busy      <= '0;
            r_rows      <= '0;
            r_err_order <= 1'b0;
            r_all_done  <= 1'b0;
        end else begin
            r_all_done <= 1'b0;
            // The selected PE is always free, so its set and clear never collide.
            r_busy     <= (r_busy & ~pe_row_done) | w_busy_set;
            case (r_state)
                S_ASSIGN: begin
                    if (in_valid && w_in_ready) begin
                        r_hold_val  <= in_val;
                        r_hold_row  <= in_row;
                        r_hold_col  <= in_col;
                        r_hold_last <= in_last;
                        r_hold_v    <= 1'b1;
                        r_cur_pe    <= w_sel;
                        r_rr_ptr    <= w_rr_next;
                        r_rows      <= r_rows + {{IDX_W{1'b0}}, 1'b1};
                        r_state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (!r_hold_last && in_valid && (in_row < r_hold_row)) begin
                            r_err_order <= 1'b1;
                        end
                        if (!w_pe_last) begin
                            r_hold_val  <= in_val;
                            r_hold_row  <= in_row;
                            r_hold_col  <= in_col;
                            r_hold_last <= in_last;
                        end else begin
                            r_hold_v <= 1'b0;
                            r_state  <= r_hold_last ? S_DRAIN : S_ASSIGN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_busy == '0) begin
                        r_all_done <= 1'b1;
                        r_rr_ptr   <= '0;
                        r_state    <= S_ASSIGN;
                    end
                end
                default: begin
                    r_state <= S_ASSIGN;
                end
            endcase
        end
    end

    assign in_ready        = w_in_ready;
    assign pe_valid        = w_pe_valid;
    assign pe_last         = w_pe_last;
    assign pe_val          = r_hold_val;
    assign pe_row          = r_hold_row;
    assign pe_col          = r_hold_col;
    assign pe_busy         = r_busy;
    assign rows_dispatched = r_rows;
    assign err_order       = r_err_order;
    assign all_done        = r_all_done & rst_n;

endmodule
